// File: rtl/sort_pkg.sv
// Shared sizes, element/frame types and per-stage record for the top-K sorting pipeline.
package sort_pkg;

  localparam int unsigned M     = 8;
  localparam int unsigned N     = 8;
  localparam int unsigned W     = 3;
  localparam int unsigned IDX_W = $clog2(M);

  localparam logic SORT_MAX = 1'b0;
  localparam logic SORT_MIN = 1'b1;

  typedef logic [N-1:0]     elem_t;
  typedef elem_t [M-1:0]    frame_t;
  typedef logic [M-1:0]     mask_t;
  typedef logic [IDX_W-1:0] idx_t;
  typedef elem_t [W-1:0]    res_y_t;
  typedef idx_t [W-1:0]     res_idx_t;
  typedef logic [W-1:0]     res_vld_t;

  // One pipeline stage: remaining frame state plus the results gathered so far.
  typedef struct packed {
    logic     vld;
    logic     mode;
    mask_t    mask;
    frame_t   val;
    res_y_t   y;
    res_idx_t idx;
    res_vld_t yv;
  } stage_t;

endpackage

// File: rtl/sort_topk_pipe_if.sv
// Frame-in / ranked-result-out handshake bundle for sort_topk_pipe.
interface sort_topk_pipe_if;
  import sort_pkg::*;

  logic     i_valid;
  logic     o_ready;
  frame_t   i_chi;
  mask_t    i_mask;
  logic     i_mode;
  logic     o_valid;
  logic     i_ready;
  res_y_t   o_y_q;
  res_idx_t o_idx;
  res_vld_t o_y_vld;

  modport slave (
    input  i_valid, i_chi, i_mask, i_mode, i_ready,
    output o_ready, o_valid, o_y_q, o_idx, o_y_vld
  );

  modport master (
    output i_valid, i_chi, i_mask, i_mode, i_ready,
    input  o_ready, o_valid, o_y_q, o_idx, o_y_vld
  );

endinterface

// File: rtl/sort_sel_stage.sv
// Combinational pick of the best masked element (max or min); ties go to the lowest index.
module sort_sel_stage
  import sort_pkg::*;
(
  input  frame_t i_val,
  input  mask_t  i_mask,
  input  logic   i_mode,
  output elem_t  o_best,
  output idx_t   o_idx,
  output logic   o_found,
  output mask_t  o_mask
);

  elem_t w_best;
  idx_t  w_idx;
  logic  w_found;
  logic  w_better;

  always_comb begin
    w_best   = '0;
    w_idx    = '0;
    w_found  = 1'b0;
    w_better = 1'b0;
    for (int i = 0; i < M; i++) begin
      // Strict compare keeps the earlier index on equal values.
      w_better = (i_mode == SORT_MAX) ? (i_val[i] > w_best) : (i_val[i] < w_best);
      if (i_mask[i] && (!w_found || w_better)) begin
        w_best  = i_val[i];
        w_idx   = IDX_W'(i);
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    o_mask = i_mask;
    if (w_found) o_mask[w_idx] = 1'b0;
  end

  assign o_best  = w_best;
  assign o_idx   = w_idx;
  assign o_found = w_found;

endmodule

// File: rtl/sort_topk_pipe.sv
// K-stage top-K selector: stage k extracts the k-th best element; all stages advance together.
module sort_topk_pipe
  import sort_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  sort_topk_pipe_if.slave  io_bus
);

  stage_t r_st  [W];
  stage_t w_nxt [W];
  logic   w_en;

  // Whole-pipe enable: a stalled output freezes every stage, bubbles included.
  assign w_en           = !r_st[W-1].vld || io_bus.i_ready;
  assign io_bus.o_ready = w_en;

  for (genvar k = 0; k < W; k++) begin : g_stage
    stage_t w_in;
    stage_t w_out;
    elem_t  w_best;
    idx_t   w_idx;
    logic   w_found;
    mask_t  w_mask;

    if (k == 0) begin : g_first
      always_comb begin
        w_in      = '0;
        w_in.vld  = io_bus.i_valid;
        w_in.mode = io_bus.i_mode;
        w_in.mask = io_bus.i_mask;
        w_in.val  = io_bus.i_chi;
      end
    end else begin : g_next
      assign w_in = r_st[k-1];
    end

    sort_sel_stage u_sel (
      .i_val   (w_in.val),
      .i_mask  (w_in.mask),
      .i_mode  (w_in.mode),
      .o_best  (w_best),
      .o_idx   (w_idx),
      .o_found (w_found),
      .o_mask  (w_mask)
    );

    always_comb begin
      w_out        = w_in;
      w_out.mask   = w_mask;
      w_out.y[k]   = w_best;
      w_out.idx[k] = w_idx;
      w_out.yv[k]  = w_found;
    end

    assign w_nxt[k] = w_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < W; k++) r_st[k] <= '0;
    end else if (w_en) begin
      for (int k = 0; k < W; k++) r_st[k] <= w_nxt[k];
    end
  end

  assign io_bus.o_valid = r_st[W-1].vld;
  assign io_bus.o_y_q   = r_st[W-1].y;
  assign io_bus.o_idx   = r_st[W-1].idx;
  assign io_bus.o_y_vld = r_st[W-1].yv;

endmodule

// File: tb/tb_sort_topk_pipe.sv
// Directed and random-stream bench for sort_topk_pipe (M=8, N=8, K=3).
module tb_sort_topk_pipe;
  import sort_pkg::*;

  typedef struct packed {
    res_y_t   y;
    res_idx_t idx;
    res_vld_t vld;
  } res_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  sort_topk_pipe_if bus ();

  sort_topk_pipe dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  frame_t f1;
  frame_t f4;

  // Independent reference: repeated best-of-remaining extraction.
  function automatic res_t ref_model(input frame_t v, input mask_t m, input logic mode);
    res_t  r;
    mask_t mm;
    int    bi;
    r  = '0;
    mm = m;
    for (int k = 0; k < W; k++) begin
      bi = -1;
      for (int i = 0; i < M; i++) begin
        if (mm[i]) begin
          if (bi < 0) bi = i;
          else if (mode ? (v[i] < v[bi]) : (v[i] > v[bi])) bi = i;
        end
      end
      if (bi >= 0) begin
        r.y[k]   = v[bi];
        r.idx[k] = IDX_W'(bi);
        r.vld[k] = 1'b1;
        mm[bi]   = 1'b0;
      end
    end
    return r;
  endfunction

  function automatic res_t grab();
    res_t r;
    r.y   = bus.o_y_q;
    r.idx = bus.o_idx;
    r.vld = bus.o_y_vld;
    return r;
  endfunction

  // Sends one frame, then waits (bounded) for o_valid; lat counts cycles after acceptance.
  task automatic send_and_capture(input frame_t v, input mask_t m, input logic mode,
                                  output res_t r, output int lat);
    @(posedge clk); #1;
    bus.i_valid = 1'b1;
    bus.i_chi   = v;
    bus.i_mask  = m;
    bus.i_mode  = mode;
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!bus.o_valid && lat < 20) begin
      lat++;
      @(negedge clk);
    end
    r = grab();
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (bus.o_valid !== 1'b0 || grab() !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b out=%h, required valid=0 out=0", bus.o_valid, grab());
    end
    checks++;
    if (bus.o_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b, required 1", bus.o_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: ready=%b valid=%b, required ready=1 valid=0",
               bus.o_ready, bus.o_valid);
    end
  endtask

  task automatic test_desc();
    res_t r;
    int   lat;
    send_and_capture(f1, 8'hFF, SORT_MAX, r, lat);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL desc_latency: got %0d, required 3", lat);
    end
    checks++;
    if (r.y !== {8'd7, 8'd8, 8'd9} || r.idx !== {3'd3, 3'd5, 3'd1} || r.vld !== 3'b111) begin
      errors++;
      $display("FAIL desc_result: got y=%h idx=%h vld=%b, required y=070809 idx=3,5,1 vld=111",
               r.y, r.idx, r.vld);
    end
  endtask

  task automatic test_back_to_back();
    res_t r;
    int   n;
    @(posedge clk); #1;
    bus.i_valid = 1'b1;
    bus.i_chi   = f1;
    bus.i_mask  = 8'hFF;
    bus.i_mode  = SORT_MIN;
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_mode  = SORT_MAX;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.o_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    r = grab();
    checks++;
    if (bus.o_valid !== 1'b1 || r.y !== {8'd3, 8'd2, 8'd1} || r.idx !== {3'd4, 3'd6, 3'd2}
        || r.vld !== 3'b111) begin
      errors++;
      $display("FAIL b2b_asc: valid=%b y=%h idx=%h vld=%b, required y=030201 idx=4,6,2 vld=111",
               bus.o_valid, r.y, r.idx, r.vld);
    end
    @(negedge clk);
    r = grab();
    checks++;
    if (bus.o_valid !== 1'b1 || r.y !== {8'd7, 8'd8, 8'd9} || r.idx !== {3'd3, 3'd5, 3'd1}) begin
      errors++;
      $display("FAIL b2b_desc: valid=%b y=%h idx=%h, required valid=1 y=070809 idx=3,5,1",
               bus.o_valid, r.y, r.idx);
    end
  endtask

  task automatic test_ties_mask();
    res_t r;
    int   lat;
    send_and_capture(f4, 8'hFF, SORT_MAX, r, lat);
    checks++;
    if (r.y !== {3{8'd4}} || r.idx !== {3'd2, 3'd1, 3'd0} || r.vld !== 3'b111) begin
      errors++;
      $display("FAIL ties_max: got y=%h idx=%h vld=%b, required y=040404 idx=2,1,0 vld=111",
               r.y, r.idx, r.vld);
    end
    send_and_capture(f4, 8'hF0, SORT_MIN, r, lat);
    checks++;
    if (r.y !== {3{8'd4}} || r.idx !== {3'd6, 3'd5, 3'd4} || r.vld !== 3'b111) begin
      errors++;
      $display("FAIL ties_min: got y=%h idx=%h vld=%b, required y=040404 idx=6,5,4 vld=111",
               r.y, r.idx, r.vld);
    end
    send_and_capture(f1, 8'h05, SORT_MAX, r, lat);
    checks++;
    if (r.y !== {8'd0, 8'd1, 8'd5} || r.idx !== {3'd0, 3'd2, 3'd0} || r.vld !== 3'b011) begin
      errors++;
      $display("FAIL mask_05: got y=%h idx=%h vld=%b, required y=000105 idx=0,2,0 vld=011",
               r.y, r.idx, r.vld);
    end
    send_and_capture(f1, 8'h00, SORT_MIN, r, lat);
    checks++;
    if (r !== '0) begin
      errors++;
      $display("FAIL mask_empty: got %h, required 0", r);
    end
  endtask

  // Streams frames against the reference queue; checks order, stall freeze and o_ready.
  task automatic run_stream(input int n_frames, input bit rnd, input int st_lo, input int st_hi);
    res_t   q[$];
    res_t   cur;
    res_t   snap;
    frame_t dv[5];
    mask_t  dm[5];
    logic   dmd[5];
    int     sent, got, cyc, extra;
    logic   hold, prev_stall;
    dv[0] = f1;  dm[0] = 8'hFF; dmd[0] = SORT_MAX;
    dv[1] = f1;  dm[1] = 8'hFF; dmd[1] = SORT_MIN;
    dv[2] = f4;  dm[2] = 8'h3C; dmd[2] = SORT_MAX;
    dv[3] = f1;  dm[3] = 8'hA0; dmd[3] = SORT_MIN;
    dv[4] = f1;  dm[4] = 8'h06; dmd[4] = SORT_MAX;
    sent = 0; got = 0; cyc = 0; hold = 1'b0; prev_stall = 1'b0; snap = '0;
    while (got < n_frames && cyc < n_frames * 8 + 50) begin
      @(posedge clk); #1;
      if (!hold) begin
        if (sent < n_frames && (!rnd || $urandom_range(0, 3) != 0)) begin
          bus.i_valid = 1'b1;
          if (rnd) begin
            for (int i = 0; i < M; i++)
              bus.i_chi[i] = elem_t'($urandom_range(0, ($urandom_range(0, 1) != 0) ? 3 : 255));
            bus.i_mask = ($urandom_range(0, 3) == 0) ? 8'hFF : mask_t'($urandom_range(0, 255));
            bus.i_mode = logic'($urandom_range(0, 1));
          end else begin
            bus.i_chi  = dv[sent];
            bus.i_mask = dm[sent];
            bus.i_mode = dmd[sent];
          end
        end else begin
          bus.i_valid = 1'b0;
        end
      end
      bus.i_ready = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= st_lo && cyc <= st_hi);
      @(negedge clk);
      cur = grab();
      checks++;
      if (bus.o_ready !== !(bus.o_valid && !bus.i_ready)) begin
        errors++;
        $display("FAIL ready_rule: cyc %0d ready=%b valid=%b i_ready=%b", cyc, bus.o_ready,
                 bus.o_valid, bus.i_ready);
      end
      if (prev_stall) begin
        checks++;
        if (bus.o_valid !== 1'b1 || cur !== snap) begin
          errors++;
          $display("FAIL stall_hold: cyc %0d got %h valid=%b, required %h valid=1", cyc, cur,
                   bus.o_valid, snap);
        end
      end
      if (bus.o_valid && bus.i_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL stream_spurious: cyc %0d got %h with nothing expected", cyc, cur);
        end else begin
          if (cur !== q[0]) begin
            errors++;
            $display("FAIL stream_frame%0d: got %h, required %h", got, cur, q[0]);
          end
          void'(q.pop_front());
        end
        got++;
      end
      prev_stall = bus.o_valid && !bus.i_ready;
      snap       = cur;
      if (bus.i_valid && bus.o_ready) begin
        q.push_back(ref_model(bus.i_chi, bus.i_mask, bus.i_mode));
        sent++;
        hold = 1'b0;
      end else begin
        hold = bus.i_valid;
      end
      cyc++;
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.o_valid) extra++;
    end
    checks++;
    if (got !== n_frames || q.size() != 0 || extra !== 0) begin
      errors++;
      $display("FAIL stream_count: delivered %0d pending %0d extra %0d, required %0d/0/0",
               got, q.size(), extra, n_frames);
    end
  endtask

  task automatic test_stall();
    run_stream(5, 1'b0, 4, 6);
  endtask

  task automatic test_random();
    run_stream(1000, 1'b1, 0, 0);
  endtask

  task automatic test_async_reset();
    res_t r;
    int   lat;
    int   stale;
    @(posedge clk); #1;
    bus.i_valid = 1'b1;
    bus.i_chi   = f1;
    bus.i_mask  = 8'hFF;
    bus.i_mode  = SORT_MAX;
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_mode  = SORT_MIN;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.o_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_precond: o_valid=%b, required 1", bus.o_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.o_valid !== 1'b0 || grab() !== '0 || bus.o_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: valid=%b out=%h ready=%b, required 0/0/1", bus.o_valid, grab(),
               bus.o_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.o_valid) stale++;
    end
    checks++;
    if (stale !== 0) begin
      errors++;
      $display("FAIL stale_valid: %0d cycles of o_valid after reset, required 0", stale);
    end
    send_and_capture(f1, 8'hFF, SORT_MIN, r, lat);
    checks++;
    if (lat !== 3 || r.y !== {8'd3, 8'd2, 8'd1} || r.idx !== {3'd4, 3'd6, 3'd2}) begin
      errors++;
      $display("FAIL post_rst_frame: lat=%0d y=%h idx=%h, required 3 y=030201 idx=4,6,2",
               lat, r.y, r.idx);
    end
  endtask

  initial begin
    f1          = {8'd6, 8'd2, 8'd8, 8'd3, 8'd7, 8'd1, 8'd9, 8'd5};
    f4          = {8{8'd4}};
    bus.i_valid = 1'b0;
    bus.i_chi   = '0;
    bus.i_mask  = '0;
    bus.i_mode  = 1'b0;
    bus.i_ready = 1'b1;
    test_reset();
    test_desc();
    test_back_to_back();
    test_ties_mask();
    test_stall();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
